idct_block_seq: RTL and testbench

Sequencer that shares one 8-lane 1-D IDCT row unit between the row pass and the column pass of an 8x8 2-D IDCT. It accepts eight 128-bit coefficient rows and issues each one to the shared unit. It collects the results in an internal transpose buffer, re-issues the eight buffer columns to the same unit, and streams the finished block out as eight rows over a valid/ready handshake. It sits between the coefficient source and the pixel reconstruction stage and owns the only path into the 1-D unit.

---
 rtl/idct_block_seq_pkg.sv | 32 +++
 rtl/idct_block_seq_if.sv | 34 +++
 rtl/idct_block_seq_tbuf.sv | 44 ++++
 rtl/idct_block_seq.sv | 148 ++++++++++++++
 tb/tb_idct_block_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idct_block_seq_pkg.sv
// Shared types for the 8x8 IDCT block sequencer.
// Lane geometry, FSM state encoding and a lane slice helper.
package idct_pkg;

  localparam int LANE_W = 16;
  localparam int LANES  = 8;
  localparam int ROW_W  = LANE_W * LANES;
  localparam int IDX_W  = 3;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [IDX_W-1:0]  idx_t;

  localparam idx_t IDX_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_ROW_FLUSH,
    S_COL,
    S_COL_FLUSH,
    S_OUT
  } idct_seq_state_t;

  function automatic lane_t lane_of(
    input row_t row,
    input idx_t i
  );
    return row[int'(i)*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/idct_block_seq_if.sv
// Row-in / row-out stream handshakes of the IDCT sequencer.
// The sequencer takes the slave side, the source/sink the master side.
interface idct_block_seq_if;
  import idct_pkg::*;

  logic in_valid;
  logic in_ready;
  row_t in_row;
  logic out_valid;
  logic out_ready;
  logic out_last;
  row_t out_row;

  modport master (
    output in_valid,
    output in_row,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_row,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_row,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_row,
    output out_last
  );

endinterface

// File: rtl/idct_block_seq_tbuf.sv
// LANES x LANES transpose buffer with row/column read and write ports.
// Contents are deliberately not reset; every block overwrites them.
module idct_tbuf
  import idct_pkg::*;
(
  input  logic clk,
  input  idx_t i_rrow_idx,
  output row_t o_rrow,
  input  idx_t i_rcol_idx,
  output row_t o_rcol,
  input  logic i_wrow_en,
  input  idx_t i_wrow_idx,
  input  row_t i_wrow,
  input  logic i_wcol_en,
  input  idx_t i_wcol_idx,
  input  row_t i_wcol
);

  lane_t r_mem [LANES][LANES];

  always_ff @(posedge clk) begin
    for (int r = 0; r < LANES; r++) begin
      for (int c = 0; c < LANES; c++) begin
        if (i_wrow_en && i_wrow_idx == idx_t'(r)) begin
          r_mem[r][c] <= lane_of(i_wrow, idx_t'(c));
        end else if (i_wcol_en && i_wcol_idx == idx_t'(c)) begin
          r_mem[r][c] <= lane_of(i_wcol, idx_t'(r));
        end
      end
    end
  end

  always_comb begin
    o_rrow = '0;
    o_rcol = '0;
    for (int c = 0; c < LANES; c++) begin
      o_rrow[c*LANE_W +: LANE_W] = r_mem[i_rrow_idx][c];
    end
    for (int r = 0; r < LANES; r++) begin
      o_rcol[r*LANE_W +: LANE_W] = r_mem[r][i_rcol_idx];
    end
  end

endmodule

// File: rtl/idct_block_seq.sv
// Shares one 1-D IDCT row unit between the row and column passes.
// Rows in, transpose buffer, columns re-issued, rows streamed out.
module idct_block_seq
  import idct_pkg::*;
#(
  parameter int UNIT_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  idct_block_seq_if.slave s_if,
  output row_t            unit_in,
  input  row_t            unit_out,
  output logic            busy
);

  idct_seq_state_t r_state;
  idct_seq_state_t w_next;

  logic                r_ready;
  logic                r_issue;
  logic [UNIT_LAT-1:0] r_tag;
  idx_t                r_cnt;
  idx_t                r_cap;
  idx_t                r_o;
  row_t                r_unit_in;

  row_t w_row_rd;
  row_t w_col_rd;
  logic w_acc;
  logic w_cap;
  logic w_hs;
  logic w_out_valid;
  logic w_out_last;
  logic w_busy;
  logic w_row_pass;
  logic w_col_pass;
  logic w_col_issue;

  assign w_acc = s_if.in_valid & r_ready;
  assign w_cap = r_tag[UNIT_LAT-1];
  assign w_hs  = w_out_valid & s_if.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE) ||
                 (w_next == S_ROW);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) w_next = S_ROW;
      end
      S_ROW: begin
        if (w_acc && r_cnt == IDX_MAX)
          w_next = S_ROW_FLUSH;
      end
      S_ROW_FLUSH: begin
        if (w_cap && r_cap == IDX_MAX)
          w_next = S_COL;
      end
      S_COL: begin
        if (r_cnt == IDX_MAX)
          w_next = S_COL_FLUSH;
      end
      S_COL_FLUSH: begin
        if (w_cap && r_cap == IDX_MAX)
          w_next = S_OUT;
      end
      S_OUT: begin
        if (w_hs && r_o == IDX_MAX)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_valid = (r_state == S_OUT);
    w_out_last  = w_out_valid && (r_o == IDX_MAX);
    w_busy      = (r_state != S_IDLE);
    w_col_issue = (r_state == S_COL);
    w_row_pass  = (r_state == S_ROW) ||
                  (r_state == S_ROW_FLUSH);
    w_col_pass  = (r_state == S_COL) ||
                  (r_state == S_COL_FLUSH);
  end

  // r_issue marks the cycle unit_in holds a live operand; tags trail it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unit_in <= '0;
      r_issue   <= 1'b0;
      r_tag     <= '0;
      r_cnt     <= '0;
      r_cap     <= '0;
      r_o       <= '0;
    end else begin
      r_issue  <= w_acc | w_col_issue;
      r_tag[0] <= r_issue;
      for (int k = 1; k < UNIT_LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
      if (w_acc) begin
        r_unit_in <= s_if.in_row;
      end else if (w_col_issue) begin
        r_unit_in <= w_col_rd;
      end
      if (w_acc || w_col_issue) begin
        r_cnt <= r_cnt + idx_t'(1);
      end
      if (w_cap) begin
        r_cap <= r_cap + idx_t'(1);
      end
      if (w_hs) begin
        r_o <= r_o + idx_t'(1);
      end
    end
  end

  idct_tbuf u_tbuf (
    .clk        (clk),
    .i_rrow_idx (r_o),
    .o_rrow     (w_row_rd),
    .i_rcol_idx (r_cnt),
    .o_rcol     (w_col_rd),
    .i_wrow_en  (w_cap & w_row_pass),
    .i_wrow_idx (r_cap),
    .i_wrow     (unit_out),
    .i_wcol_en  (w_cap & w_col_pass),
    .i_wcol_idx (r_cap),
    .i_wcol     (unit_out)
  );

  assign s_if.in_ready  = r_ready;
  assign s_if.out_valid = w_out_valid;
  assign s_if.out_last  = w_out_last;
  assign s_if.out_row   = w_row_rd;
  assign unit_in        = r_unit_in;
  assign busy           = w_busy;

endmodule

// File: tb/tb_idct_block_seq.sv
// Directed bench for idct_block_seq: pass-through unit at latency 1,
// plus four +1 unit instances sweeping UNIT_LAT 1..4.
module tb_idct_block_seq;
  import idct_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic row_t make_row(input int base, input int r);
    row_t o;
    o = '0;
    for (int i = 0; i < LANES; i++)
      o[i*LANE_W +: LANE_W] = 16'(base + r*8 + i);
    return o;
  endfunction

  function automatic row_t plus1(input row_t r);
    row_t o;
    for (int i = 0; i < LANES; i++)
      o[i*LANE_W +: LANE_W] = r[i*LANE_W +: LANE_W] + 16'd1;
    return o;
  endfunction

  idct_block_seq_if mif();
  row_t unit_in;
  row_t unit_out;
  logic busy;

  idct_block_seq #(.UNIT_LAT(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_if     (mif.slave),
    .unit_in  (unit_in),
    .unit_out (unit_out),
    .busy     (busy)
  );

  always_ff @(posedge clk) unit_out <= unit_in;

  logic       sw_valid;
  row_t       sw_row;
  logic [3:0] sw_ov;
  logic [3:0] sw_ol;
  logic [3:0] sw_rdy;
  logic [3:0] sw_busy;
  row_t       sw_or [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int D = g + 1;
    idct_block_seq_if sif();
    row_t uin;
    row_t uout;
    row_t p [D];
    logic b;
    assign sif.in_valid  = sw_valid;
    assign sif.in_row    = sw_row;
    assign sif.out_ready = 1'b1;
    idct_block_seq #(.UNIT_LAT(D)) u (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_if     (sif.slave),
      .unit_in  (uin),
      .unit_out (uout),
      .busy     (b)
    );
    always_ff @(posedge clk) begin
      p[0] <= plus1(uin);
      for (int k = 1; k < D; k++) p[k] <= p[k-1];
    end
    assign uout       = p[D-1];
    assign sw_ov[g]   = sif.out_valid;
    assign sw_ol[g]   = sif.out_last;
    assign sw_rdy[g]  = sif.in_ready;
    assign sw_busy[g] = b;
    assign sw_or[g]   = sif.out_row;
  end

  row_t src [8];
  row_t got [8];
  row_t keep [8];
  int   t_acc, n_acc, t_val, n_last, last_idx, rdy_hi, stall_bad;
  bit   tmo;

  task automatic load_src(input int base);
    for (int r = 0; r < 8; r++) src[r] = make_row(base, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mif.in_valid = 1'b0;
    end
  endtask

  task automatic send_block(input bit gaps);
    int n = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (n < 8 && guard < 100) begin
      @(negedge clk);
      guard++;
      mif.in_row   = src[n];
      mif.in_valid = !(gaps && ph);
      ph = !ph;
      if (mif.in_valid && mif.in_ready) begin
        if (n == 0) t_acc = cyc;
        n++;
      end
    end
    n_acc = n;
  endtask

  task automatic recv_block(input int stall_row, input int stall_n,
                            input bit keep_valid);
    int n = 0;
    int guard = 0;
    int st = 0;
    n_last = 0; last_idx = -1; t_val = -1;
    rdy_hi = 0; stall_bad = 0; tmo = 1'b0;
    while (n < 8) begin
      @(negedge clk);
      mif.in_valid = keep_valid;
      if (guard >= 200) begin
        tmo = 1'b1;
        break;
      end
      guard++;
      if (mif.in_ready) rdy_hi++;
      mif.out_ready = 1'b1;
      if (mif.out_valid) begin
        if (t_val < 0) t_val = cyc;
        if (n == stall_row && st > 0 &&
            (mif.out_row !== got[n] || mif.out_last))
          stall_bad++;
        got[n] = mif.out_row;
        if (n == stall_row && st < stall_n) begin
          mif.out_ready = 1'b0;
          st++;
        end else begin
          if (mif.out_last) begin
            n_last++;
            last_idx = n;
          end
          n++;
        end
      end
    end
    mif.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle(3);
    checks++; if (mif.in_ready !== 1'b0) begin errors++;
      $display("FAIL rst_in_ready got %0b want 0", mif.in_ready); end
    checks++; if (mif.out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_out_valid got %0b want 0", mif.out_valid); end
    checks++; if (mif.out_last !== 1'b0) begin errors++;
      $display("FAIL rst_out_last got %0b want 0", mif.out_last); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (unit_in !== '0) begin errors++;
      $display("FAIL rst_unit_in got %h want 0", unit_in); end
    rst_n = 1'b1;
    idle(2);
    checks++; if (mif.in_ready !== 1'b1) begin errors++;
      $display("FAIL rel_in_ready got %0b want 1", mif.in_ready); end
    checks++; if (sw_rdy !== 4'hf) begin errors++;
      $display("FAIL rel_sweep_ready got %h want f", sw_rdy); end
  endtask

  task automatic test_identity();
    row_t exp0;
    exp0 = {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    idle(2);
    load_src(0);
    send_block(1'b0);
    recv_block(-1, 0, 1'b0);
    checks++; if (tmo !== 1'b0) begin errors++;
      $display("FAIL id_timeout got %0b want 0", tmo); end
    checks++; if (t_val - t_acc !== 20) begin errors++;
      $display("FAIL id_latency got %0d want 20", t_val - t_acc); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (got[r] !== src[r]) begin errors++;
        $display("FAIL id_row%0d got %h want %h", r, got[r], src[r]); end
    end
    checks++; if (got[0] !== exp0) begin errors++;
      $display("FAIL id_row0_lanes got %h want %h", got[0], exp0); end
    checks++; if (n_last !== 1 || last_idx !== 7) begin errors++;
      $display("FAIL id_last got %0d@%0d want 1@7", n_last, last_idx); end
    checks++; if (rdy_hi !== 0) begin errors++;
      $display("FAIL id_ready_drain got %0d want 0", rdy_hi); end
    idle(1);
    checks++; if (busy !== 1'b0 || mif.in_ready !== 1'b1) begin errors++;
      $display("FAIL id_back_idle got %0b%0b want 01", busy, mif.in_ready); end
  endtask

  task automatic test_source_gaps();
    idle(2);
    load_src(0);
    send_block(1'b1);
    recv_block(-1, 0, 1'b1);
    checks++; if (n_acc !== 8 || tmo !== 1'b0) begin errors++;
      $display("FAIL gap_accepts got %0d tmo %0b want 8", n_acc, tmo); end
    checks++; if (rdy_hi !== 0) begin errors++;
      $display("FAIL gap_ready_low got %0d want 0", rdy_hi); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (got[r] !== src[r]) begin errors++;
        $display("FAIL gap_row%0d got %h want %h", r, got[r], src[r]); end
    end
    checks++; if (n_last !== 1 || last_idx !== 7) begin errors++;
      $display("FAIL gap_last got %0d@%0d want 1@7", n_last, last_idx); end
  endtask

  task automatic test_backpressure();
    idle(2);
    load_src(0);
    send_block(1'b0);
    recv_block(3, 5, 1'b0);
    checks++; if (tmo !== 1'b0) begin errors++;
      $display("FAIL bp_timeout got %0b want 0", tmo); end
    checks++; if (stall_bad !== 0) begin errors++;
      $display("FAIL bp_hold got %0d want 0", stall_bad); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (got[r] !== src[r]) begin errors++;
        $display("FAIL bp_row%0d got %h want %h", r, got[r], src[r]); end
    end
    checks++; if (n_last !== 1 || last_idx !== 7) begin errors++;
      $display("FAIL bp_last got %0d@%0d want 1@7", n_last, last_idx); end
  endtask

  task automatic test_latency_sweep();
    row_t sgot [4][8];
    int   sn [4];
    int   sfirst [4];
    int   slast [4];
    int   t0 = 0;
    int   rdy_bad = 0;
    for (int g = 0; g < 4; g++) begin
      sn[g] = 0; sfirst[g] = -1; slast[g] = 0;
    end
    idle(2);
    load_src(0);
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      sw_valid = 1'b1;
      sw_row   = src[r];
      if (r == 0) t0 = cyc;
      if (sw_rdy !== 4'hf) rdy_bad++;
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      sw_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        if (sw_ov[g]) begin
          if (sfirst[g] < 0) sfirst[g] = cyc;
          if (sn[g] < 8) sgot[g][sn[g]] = sw_or[g];
          sn[g]++;
          if (sw_ol[g]) slast[g]++;
        end
      end
    end
    checks++; if (rdy_bad !== 0) begin errors++;
      $display("FAIL sw_accept got %0d stalls want 0", rdy_bad); end
    for (int g = 0; g < 4; g++) begin
      checks++; if (sfirst[g] - t0 !== 18 + 2*(g+1)) begin errors++;
        $display("FAIL sw_lat%0d got %0d want %0d", g+1,
                 sfirst[g] - t0, 18 + 2*(g+1)); end
      checks++; if (sn[g] !== 8 || slast[g] !== 1) begin errors++;
        $display("FAIL sw_count%0d got %0d/%0d want 8/1", g+1,
                 sn[g], slast[g]); end
      checks++; if (sw_busy[g] !== 1'b0) begin errors++;
        $display("FAIL sw_idle%0d got %0b want 0", g+1, sw_busy[g]); end
      for (int r = 0; r < 8; r++) begin
        checks++; if (sgot[g][r] !== make_row(2, r)) begin errors++;
          $display("FAIL sw_l%0d_row%0d got %h want %h", g+1, r,
                   sgot[g][r], make_row(2, r)); end
      end
    end
  endtask

  task automatic test_reset_mid_col();
    int guard = 0;
    idle(2);
    load_src(0);
    send_block(1'b0);
    while (cyc < t_acc + 12 && guard < 50) begin
      @(negedge clk);
      mif.in_valid = 1'b0;
      guard++;
    end
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL mid_busy_before got %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({mif.in_ready, mif.out_valid, mif.out_last, busy}
                  !== 4'b0000) begin errors++;
      $display("FAIL mid_rst_outs got %b want 0000",
               {mif.in_ready, mif.out_valid, mif.out_last, busy}); end
    checks++; if (unit_in !== '0) begin errors++;
      $display("FAIL mid_rst_unit_in got %h want 0", unit_in); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    checks++; if (mif.in_ready !== 1'b1) begin errors++;
      $display("FAIL mid_rel_ready got %0b want 1", mif.in_ready); end
    load_src(32);
    send_block(1'b0);
    recv_block(-1, 0, 1'b0);
    checks++; if (tmo !== 1'b0 || t_val - t_acc !== 20) begin errors++;
      $display("FAIL mid_latency got %0d want 20", t_val - t_acc); end
    for (int r = 0; r < 8; r++) begin
      checks++; if (got[r] !== src[r]) begin errors++;
        $display("FAIL mid_row%0d got %h want %h", r, got[r], src[r]); end
    end
    checks++; if (n_last !== 1 || last_idx !== 7) begin errors++;
      $display("FAIL mid_last got %0d@%0d want 1@7", n_last, last_idx); end
  endtask

  task automatic test_back_to_back();
    int ta;
    idle(2);
    load_src(0);
    send_block(1'b0);
    ta = t_acc;
    recv_block(-1, 0, 1'b0);
    for (int r = 0; r < 8; r++) keep[r] = got[r];
    load_src(256);
    send_block(1'b0);
    checks++; if (t_acc - ta !== 28) begin errors++;
      $display("FAIL b2b_period got %0d want 28", t_acc - ta); end
    recv_block(-1, 0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      checks++; if (keep[r] !== make_row(0, r)) begin errors++;
        $display("FAIL b2b_a_row%0d got %h want %h", r, keep[r],
                 make_row(0, r)); end
      checks++; if (got[r] !== make_row(256, r)) begin errors++;
        $display("FAIL b2b_b_row%0d got %h want %h", r, got[r],
                 make_row(256, r)); end
    end
    checks++; if (tmo !== 1'b0 || n_last !== 1) begin errors++;
      $display("FAIL b2b_last got %0d tmo %0b want 1", n_last, tmo); end
  endtask

  initial begin
    mif.in_valid  = 1'b0;
    mif.in_row    = '0;
    mif.out_ready = 1'b1;
    sw_valid      = 1'b0;
    sw_row        = '0;
    test_reset();
    test_identity();
    test_source_gaps();
    test_backpressure();
    test_latency_sweep();
    test_reset_mid_col();
    test_back_to_back();
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
